// File: rtl/user_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// user_wb_pkg
// Shared definitions for the two-master Wishbone arbiter:
//   - arb_state_e      : arbiter FSM states (IDLE, GNT0, GNT1)
//   - WB_TIMEOUT_DATA  : read data returned to a master whose transfer was
//                        terminated by the timeout
//   - WB_AW_DEFAULT / WB_DW_DEFAULT : default address / data widths
//   - timeout_data_bit : bit i of WB_TIMEOUT_DATA, repeated every 32 bits so
//                        that any data width can be filled from it
// ---------------------------------------------------------------------------
package user_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  localparam int WB_AW_DEFAULT = 32;
  localparam int WB_DW_DEFAULT = 32;

  function automatic logic timeout_data_bit(input int unsigned idx);
    logic [4:0] bit_idx;
    bit_idx = idx[4:0];
    return WB_TIMEOUT_DATA[bit_idx];
  endfunction

endpackage

// File: rtl/user_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// user_wb_arbiter_if
// One Wishbone classic link (master <-> slave).
//   cyc, stb, we, sel, adr, dat_w : driven by the master
//   ack, dat_r                    : driven by the slave
// Modports:
//   master : the side that issues the cycle
//   slave  : the side that answers it
// ---------------------------------------------------------------------------
interface user_wb_arbiter_if
  import user_wb_pkg::*;
#(
  parameter int AW = WB_AW_DEFAULT,
  parameter int DW = WB_DW_DEFAULT
);

  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic            ack;
  logic [DW-1:0]   dat_r;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output ack, dat_r
  );

endinterface

// File: rtl/user_wb_rr_pick.sv
// ---------------------------------------------------------------------------
// user_wb_rr_pick
// Two-input round-robin pick.
//   req   in  2  request per master
//   last  in  1  index of the master granted most recently
//   valid out 1  at least one request present
//   pick  out 1  index of the master to grant (only meaningful with valid)
// A lone request wins outright; with both requesting, the master that was
// not granted last wins.
// ---------------------------------------------------------------------------
module user_wb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    pick  = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/user_wb_arbiter.sv
// ---------------------------------------------------------------------------
// user_wb_arbiter
// Two-master, one-slave Wishbone classic arbiter. Master 0 is the management
// SoC bus, master 1 an internal requester; both share one slave. One grant is
// held per bus cycle, and contention alternates between the masters.
//
// Ports:
//   wb_clk_i   in   clock for all logic
//   wb_rst_ni  in   synchronous, active-low reset
//   m0, m1     slave modport of user_wb_arbiter_if (arbiter answers masters)
//   s          master modport of user_wb_arbiter_if (arbiter drives slave)
//   gnt_o      out  one-hot current grant, 2'b00 when idle
//   err_o      out  one-cycle pulse when a transfer is ended by timeout
//
// Build option: define USER_WB_ARB_TIMEOUT_EN to terminate a granted transfer
// that has seen no slave ack for TIMEOUT cycles. Without it a granted
// transfer waits for the ack indefinitely and err_o stays 0.
// ---------------------------------------------------------------------------
module user_wb_arbiter
  import user_wb_pkg::*;
#(
  parameter int AW      = WB_AW_DEFAULT,
  parameter int DW      = WB_DW_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  user_wb_arbiter_if.slave   m0,
  user_wb_arbiter_if.slave   m1,
  user_wb_arbiter_if.master  s,
  output logic [1:0]         gnt_o,
  output logic               err_o
);

  localparam int SW = DW / 8;

  if (TIMEOUT < 2) begin : g_timeout_range
    $error("user_wb_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_e state_reg, state_next;
  logic       last_reg, last_next;

  // Masters gathered into arrays so the mux can be indexed by grant.
  logic [1:0]    m_cyc, m_stb, m_we, m_req, m_ack;
  logic [SW-1:0] m_sel  [2];
  logic [AW-1:0] m_adr  [2];
  logic [DW-1:0] m_dat  [2];
  logic [DW-1:0] m_rdat [2];

  assign m_cyc    = {m1.cyc, m0.cyc};
  assign m_stb    = {m1.stb, m0.stb};
  assign m_we     = {m1.we,  m0.we};
  assign m_sel[0] = m0.sel;
  assign m_sel[1] = m1.sel;
  assign m_adr[0] = m0.adr;
  assign m_adr[1] = m1.adr;
  assign m_dat[0] = m0.dat_w;
  assign m_dat[1] = m1.dat_w;

  assign m0.ack   = m_ack[0];
  assign m1.ack   = m_ack[1];
  assign m0.dat_r = m_rdat[0];
  assign m1.dat_r = m_rdat[1];

  assign m_req = m_cyc & m_stb;

  logic pick_valid, pick;

  user_wb_rr_pick u_pick (
    .req   (m_req),
    .last  (last_reg),
    .valid (pick_valid),
    .pick  (pick)
  );

  // Index of the master currently granted (only meaningful outside IDLE).
  logic gsel;
  assign gsel = (state_reg == GNT1);

  // Timeout response word: the 32-bit pattern repeated/truncated to DW.
  logic [DW-1:0] timeout_resp;
  for (genvar gi = 0; gi < DW; gi++) begin : g_timeout_resp
    assign timeout_resp[gi] = timeout_data_bit(gi);
  end

  logic timeout_hit;

`ifdef USER_WB_ARB_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_reg, cnt_next;

  // Counts granted cycles without ack. Every grant is preceded by at least
  // one IDLE cycle, which clears the count, so a fresh grant starts at 0.
  always_comb begin
    cnt_next = '0;
    if (state_reg != IDLE && !s.ack) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign timeout_hit = (state_reg != IDLE) && (cnt_reg == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;   // master 0 wins the first contention
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    gnt_o      = 2'b00;
    err_o      = 1'b0;
    s.cyc      = 1'b0;
    s.stb      = 1'b0;
    s.we       = 1'b0;
    s.sel      = '0;
    s.adr      = '0;
    s.dat_w    = '0;
    m_ack      = 2'b00;
    m_rdat[0]  = '0;
    m_rdat[1]  = '0;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = pick ? GNT1 : GNT0;
        end
      end

      GNT0, GNT1: begin
        gnt_o[gsel] = 1'b1;
        // Slave follows the granted master directly, so a dropped cyc
        // reaches the slave in the same cycle.
        s.cyc   = m_cyc[gsel];
        s.stb   = m_stb[gsel];
        s.we    = m_we[gsel];
        s.sel   = m_sel[gsel];
        s.adr   = m_adr[gsel];
        s.dat_w = m_dat[gsel];

        if (s.ack) begin
          // A real ack beats a timeout landing on the same cycle.
          m_ack[gsel]  = 1'b1;
          m_rdat[gsel] = s.dat_r;
          state_next   = IDLE;
          last_next    = gsel;
        end else if (!m_cyc[gsel]) begin
          state_next = IDLE;
          last_next  = gsel;
        end else if (timeout_hit) begin
          s.cyc        = 1'b0;
          s.stb        = 1'b0;
          m_ack[gsel]  = 1'b1;
          m_rdat[gsel] = timeout_resp;
          err_o        = 1'b1;
          state_next   = IDLE;
          last_next    = gsel;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_user_wb_arbiter.sv
`timescale 1ns/1ps
module tb_user_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TP = 8;
`ifdef USER_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_cyc [2];
  logic        in_stb [2];
  logic        in_we  [2];
  logic [3:0]  in_sel [2];
  logic [31:0] in_adr [2];
  logic [31:0] in_dat [2];
  logic        in_ack;
  logic [31:0] in_sdat;
  logic [1:0]  gnt;
  logic        err;

  user_wb_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  user_wb_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
  user_wb_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  assign m0_if.cyc   = in_cyc[0];
  assign m0_if.stb   = in_stb[0];
  assign m0_if.we    = in_we[0];
  assign m0_if.sel   = in_sel[0];
  assign m0_if.adr   = in_adr[0];
  assign m0_if.dat_w = in_dat[0];
  assign m1_if.cyc   = in_cyc[1];
  assign m1_if.stb   = in_stb[1];
  assign m1_if.we    = in_we[1];
  assign m1_if.sel   = in_sel[1];
  assign m1_if.adr   = in_adr[1];
  assign m1_if.dat_w = in_dat[1];
  assign s_if.ack    = in_ack;
  assign s_if.dat_r  = in_sdat;

  user_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TP)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .gnt_o     (gnt),
    .err_o     (err)
  );

  typedef struct packed {
    logic [1:0]  gnt;
    logic        err;
    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr;
    logic [31:0] s_dat;
    logic        m0_ack;
    logic [31:0] m0_dat;
    logic        m1_ack;
    logic [31:0] m1_dat;
  } out_t;

  typedef struct packed {
    logic       rst_n;
    logic       r0;
    logic       r1;
    logic       ack;
    logic [1:0] gnt;
    logic       scyc;
    logic       a0;
    logic       a1;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: who owns the bus, who had it last, and how many
  // granted cycles the current owner has used (1 on the first one).
  int mdl_owner;
  int mdl_last;
  int mdl_wait;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rn, input logic r0, input logic r1, input logic ack,
                               input logic [1:0] g, input logic sc, input logic a0, input logic a1);
    vec_t v;
    v.rst_n = rn; v.r0 = r0; v.r1 = r1; v.ack = ack;
    v.gnt = g; v.scyc = sc; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  function automatic out_t sample_dut();
    out_t a;
    a.gnt    = gnt;
    a.err    = err;
    a.s_cyc  = s_if.cyc;
    a.s_stb  = s_if.stb;
    a.s_we   = s_if.we;
    a.s_sel  = s_if.sel;
    a.s_adr  = s_if.adr;
    a.s_dat  = s_if.dat_w;
    a.m0_ack = m0_if.ack;
    a.m0_dat = m0_if.dat_r;
    a.m1_ack = m1_if.ack;
    a.m1_dat = m1_if.dat_r;
    return a;
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      in_cyc[k] = 1'b0; in_stb[k] = 1'b0; in_we[k] = 1'b0;
      in_sel[k] = 4'h0; in_adr[k] = 32'h0; in_dat[k] = 32'h0;
    end
    in_ack  = 1'b0;
    in_sdat = 32'h0;
  endtask

  function automatic out_t model_eval();
    out_t e;
    int   k;
    logic ack_k;
    logic [31:0] dat_k;
    e = '0;
    if (mdl_owner >= 0) begin
      k       = mdl_owner;
      e.gnt   = (k == 0) ? 2'b01 : 2'b10;
      e.s_cyc = in_cyc[k];
      e.s_stb = in_stb[k];
      e.s_we  = in_we[k];
      e.s_sel = in_sel[k];
      e.s_adr = in_adr[k];
      e.s_dat = in_dat[k];
      ack_k   = 1'b0;
      dat_k   = 32'h0;
      if (in_ack) begin
        ack_k = 1'b1;
        dat_k = in_sdat;
      end else if (TO_EN && in_cyc[k] && mdl_wait == TP) begin
        e.s_cyc = 1'b0;
        e.s_stb = 1'b0;
        ack_k   = 1'b1;
        dat_k   = 32'hDEAD_BEEF;
        e.err   = 1'b1;
      end
      if (k == 0) begin e.m0_ack = ack_k; e.m0_dat = dat_k; end
      else        begin e.m1_ack = ack_k; e.m1_dat = dat_k; end
    end
    return e;
  endfunction

  task automatic model_step();
    logic r0, r1;
    if (!rst_n) begin
      mdl_owner = -1;
      mdl_last  = 1;
    end else if (mdl_owner < 0) begin
      r0 = in_cyc[0] && in_stb[0];
      r1 = in_cyc[1] && in_stb[1];
      if (r0 && r1)  mdl_owner = 1 - mdl_last;
      else if (r0)   mdl_owner = 0;
      else if (r1)   mdl_owner = 1;
      mdl_wait = 1;
    end else if (in_ack || !in_cyc[mdl_owner] || (TO_EN && mdl_wait == TP)) begin
      mdl_last  = mdl_owner;
      mdl_owner = -1;
    end else begin
      mdl_wait++;
    end
  endtask

  initial begin
    out_t a;
    out_t e;
    vec_t v;
    int   bad;

    // Directed table: inputs for one cycle and the outputs expected in it.
    // Single m0 read, slave acks two cycles after stb.
    vt[0]  = mkv(1, 1, 0, 0, 2'b00, 0, 0, 0);
    vt[1]  = mkv(1, 1, 0, 0, 2'b01, 1, 0, 0);
    vt[2]  = mkv(1, 1, 0, 0, 2'b01, 1, 0, 0);
    vt[3]  = mkv(1, 1, 0, 1, 2'b01, 1, 1, 0);
    vt[4]  = mkv(1, 0, 0, 0, 2'b00, 0, 0, 0);
    // Continuous contention after reset: m0, m1, m0, m1; idle acks ignored.
    vt[5]  = mkv(0, 0, 0, 0, 2'b00, 0, 0, 0);
    vt[6]  = mkv(1, 1, 1, 0, 2'b00, 0, 0, 0);
    vt[7]  = mkv(1, 1, 1, 1, 2'b01, 1, 1, 0);
    vt[8]  = mkv(1, 1, 1, 1, 2'b00, 0, 0, 0);
    vt[9]  = mkv(1, 1, 1, 1, 2'b10, 1, 0, 1);
    vt[10] = mkv(1, 1, 1, 0, 2'b00, 0, 0, 0);
    vt[11] = mkv(1, 1, 1, 1, 2'b01, 1, 1, 0);
    vt[12] = mkv(1, 1, 1, 1, 2'b00, 0, 0, 0);
    vt[13] = mkv(1, 1, 1, 1, 2'b10, 1, 0, 1);
    vt[14] = mkv(1, 0, 0, 0, 2'b00, 0, 0, 0);
    // Reset while GNT0 waits, then an m1 request is served normally.
    vt[15] = mkv(1, 1, 0, 0, 2'b00, 0, 0, 0);
    vt[16] = mkv(1, 1, 0, 0, 2'b01, 1, 0, 0);
    vt[17] = mkv(0, 1, 0, 0, 2'b01, 1, 0, 0);
    vt[18] = mkv(1, 0, 1, 0, 2'b00, 0, 0, 0);
    vt[19] = mkv(1, 0, 1, 1, 2'b10, 1, 0, 1);
    vt[20] = mkv(1, 0, 0, 0, 2'b00, 0, 0, 0);
    // m1 aborts mid-transfer with m0 pending; late slave ack ignored.
    vt[21] = mkv(1, 0, 1, 0, 2'b00, 0, 0, 0);
    vt[22] = mkv(1, 0, 1, 0, 2'b10, 1, 0, 0);
    vt[23] = mkv(1, 1, 0, 0, 2'b10, 0, 0, 0);
    vt[24] = mkv(1, 1, 0, 1, 2'b00, 0, 0, 0);
    vt[25] = mkv(1, 1, 0, 1, 2'b01, 1, 1, 0);
    vt[26] = mkv(1, 0, 0, 0, 2'b00, 0, 0, 0);

    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 256'(sample_dut()), 256'(out_t'('0)));

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      @(posedge clk); #1;
      rst_n     = v.rst_n;
      in_cyc[0] = v.r0;  in_stb[0] = v.r0;
      in_cyc[1] = v.r1;  in_stb[1] = v.r1;
      in_we[0]  = 1'b1;  in_we[1]  = 1'b0;
      in_sel[0] = 4'hF;  in_sel[1] = 4'h3;
      in_adr[0] = 32'h1000_0000; in_adr[1] = 32'h2000_0004;
      in_dat[0] = 32'hA0A0_0000; in_dat[1] = 32'hB1B1_1111;
      in_ack    = v.ack;
      in_sdat   = 32'h1234_5678;
      @(negedge clk);
      e = '0;
      e.gnt    = v.gnt;
      e.s_cyc  = v.scyc;
      e.s_stb  = v.scyc;
      if (v.gnt == 2'b01) begin
        e.s_we = 1'b1; e.s_sel = 4'hF; e.s_adr = 32'h1000_0000; e.s_dat = 32'hA0A0_0000;
      end else if (v.gnt == 2'b10) begin
        e.s_we = 1'b0; e.s_sel = 4'h3; e.s_adr = 32'h2000_0004; e.s_dat = 32'hB1B1_1111;
      end
      e.m0_ack = v.a0;
      e.m0_dat = v.a0 ? 32'h1234_5678 : 32'h0;
      e.m1_ack = v.a1;
      e.m1_dat = v.a1 ? 32'h1234_5678 : 32'h0;
      check($sformatf("vec%0d", i), 256'(sample_dut()), 256'(e));
    end

    // Hand-written: m0 request with a slave that never acks.
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_cyc[0] = 1'b1; in_stb[0] = 1'b1; in_adr[0] = 32'h0000_0040;
    in_sdat = 32'h1234_5678;
    @(negedge clk);
    check("hang_req_idle", 256'(gnt), 256'(2'b00));

`ifdef USER_WB_ARB_TIMEOUT_EN
    for (int g = 1; g <= TP; g++) begin
      @(posedge clk); #1;
      in_ack = 1'b0;
      @(negedge clk);
      a = sample_dut();
      if (g < TP)
        check($sformatf("to_wait%0d", g), 256'({a.gnt, a.s_cyc, a.m0_ack, a.m0_dat, a.err, a.m1_ack}),
              256'({2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
      else
        check("to_fire", 256'({a.gnt, a.s_cyc, a.m0_ack, a.m0_dat, a.err, a.m1_ack}),
              256'({2'b01, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}));
    end
    @(posedge clk); #1;
    in_cyc[0] = 1'b0; in_stb[0] = 1'b0;
    @(negedge clk);
    check("to_after_idle", 256'({gnt, err}), 256'({2'b00, 1'b0}));
    @(posedge clk); #1;
    in_cyc[0] = 1'b1; in_stb[0] = 1'b1;
    @(negedge clk);
    for (int g = 1; g <= TP; g++) begin
      @(posedge clk); #1;
      in_ack = (g == TP);
      @(negedge clk);
      a = sample_dut();
      if (g == TP)
        check("to_ack_wins", 256'({a.gnt, a.s_cyc, a.m0_ack, a.m0_dat, a.err}),
              256'({2'b01, 1'b1, 1'b1, 32'h1234_5678, 1'b0}));
    end
    @(posedge clk); #1;
    in_cyc[0] = 1'b0; in_stb[0] = 1'b0; in_ack = 1'b0;
    @(negedge clk);
    check("to_ack_idle", 256'({gnt, err}), 256'({2'b00, 1'b0}));
`else
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (c == 0)
        check("hold_first", 256'({gnt, s_if.cyc, m0_if.ack, err}), 256'({2'b01, 1'b1, 1'b0, 1'b0}));
      if (gnt !== 2'b01 || err !== 1'b0 || m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0 || s_if.cyc !== 1'b1)
        bad++;
    end
    check("hold_1000_bad_cycles", 256'(bad), 256'(0));
    @(posedge clk); #1;
    in_cyc[0] = 1'b0; in_stb[0] = 1'b0;
    @(negedge clk);
    check("hold_abort_scyc", 256'({gnt, s_if.cyc}), 256'({2'b01, 1'b0}));
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_abort_idle", 256'({gnt, err}), 256'({2'b00, 1'b0}));
`endif

    // Randomised traffic against the behavioural model.
    mdl_owner = -1;
    mdl_last  = 1;
    mdl_wait  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) begin
        if (in_cyc[k]) in_cyc[k] = ($urandom_range(0, 9) != 0);
        else           in_cyc[k] = ($urandom_range(0, 9) < 4);
        in_stb[k] = in_cyc[k] && ($urandom_range(0, 7) != 0);
        in_we[k]  = 1'($urandom_range(0, 1));
        in_sel[k] = 4'($urandom);
        in_adr[k] = $urandom;
        in_dat[k] = $urandom;
      end
      in_ack  = ($urandom_range(0, 3) == 0);
      in_sdat = $urandom;
      @(negedge clk);
      check($sformatf("rand%0d", c), 256'(sample_dut()), 256'(model_eval()));
      model_step();
    end

    @(posedge clk); #1;
    clear_inputs();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/user_wb_arbiter.md
# user_wb_arbiter

Two-master, one-slave Wishbone classic arbiter for the user project area. It shares the single user-side Wishbone slave resource (SoC control/debug space behind `user_proj_top`) between the management SoC bus (master 0) and an internal requester such as the core's debug/data bus (master 1). It holds one grant per bus cycle, alternates fairly under contention, and can optionally terminate hung transfers with a timeout.

## Interface
Parameters:
- `AW`, 32, address width of all ports.
- `DW`, 32, data width; `DW/8` select bits.
- `TIMEOUT`, 255, cycles a granted transfer may wait for slave ack; only used when the timeout feature is compiled in; must be ≥2.

Ports:
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_ni`  in  1  synchronous, active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 (management SoC) control.
- `m0_sel_i`  in  DW/8;  `m0_adr_i`  in  AW;  `m0_dat_i`  in  DW.
- `m0_ack_o`  out  1;  `m0_dat_o`  out  DW  master 0 response.
- `m1_*`  same set as `m0_*`, for master 1 (internal requester).
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to shared slave.
- `s_sel_o`  out  DW/8;  `s_adr_o`  out  AW;  `s_dat_o`  out  DW.
- `s_ack_i`  in  1;  `s_dat_i`  in  DW  slave response.
- `gnt_o`  out  2  one-hot current grant, `2'b00` when idle.
- `err_o`  out  1  one-cycle pulse on timeout termination.

## Operation
- FSM states: `IDLE`, `GNT0`, `GNT1`. Grant is registered.
- `IDLE`: request k = `mk_cyc_i & mk_stb_i`. One request → `GNTk`. Both → the master not granted last (`last` pointer). Neither → stay.
- `last` resets to 1, so master 0 wins the first contention.
- `GNTk`: slave outputs = master k's inputs (combinational mux on registered grant). Non-granted master sees `ack=0`, `dat=0`.
- `s_ack_i` while in `GNTk` → routed combinationally to `mk_ack_o`, `mk_dat_o = s_dat_i`; next state `IDLE`, `last ← k`.
- Granted master deasserts `mk_cyc_i` before ack → abort: slave `cyc/stb` drop the same cycle (mux follows master), state → `IDLE` next cycle, `last ← k`.
- `s_ack_i` in `IDLE` is ignored.
- In `IDLE`, all `s_*` outputs are 0; `gnt_o = 0`.
- Reset (any state, including mid-transfer): state `IDLE`, `last = 1`, counter 0; all outputs 0 from the cycle following the reset edge.

## Timing
- Request sampled in `IDLE` at edge N → `gnt_o` and `s_cyc_o/s_stb_o` high from cycle N+1.
- Ack latency to master = slave latency (zero added cycles on return path).
- Mandatory one `IDLE` cycle between consecutive grants; back-to-back from one master costs 1 bubble.
- Under continuous contention grants strictly alternate m0, m1, m0, ...

## Configuration
- Macro `USER_WB_ARB_TIMEOUT_EN`.
- Defined: `$clog2(TIMEOUT+1)`-bit counter cleared on entering `GNTk`, incremented each granted cycle without `s_ack_i`. At count `TIMEOUT-1` with no ack: arbiter drives `mk_ack_o=1`, `mk_dat_o=32'hDEAD_BEEF` (replicated/truncated to DW), forces `s_cyc_o/s_stb_o=0` that cycle, pulses `err_o`, state → `IDLE`. Ack arriving on that same cycle wins: normal ack, no `err_o`.
- Undefined: no counter, `err_o` tied 0, a granted transfer waits indefinitely.

## Structure
- Shared package `user_wb_pkg`: FSM state enum, `WB_TIMEOUT_DATA` constant (`32'hDEAD_BEEF`), default widths.
- One sub-module: `user_wb_rr_pick` (2-input round-robin pick from requests and `last`); FSM, mux and timeout stay in the top.

## Test plan
- Single m0 read, slave acks 2 cycles after stb: `gnt_o=01` at N+1, `m0_ack_o` with `s_dat_i=0x1234_5678` at N+3, `IDLE` at N+4, `m1_ack_o` never high.
- Simultaneous m0/m1 requests after reset, held continuously: grant order m0, m1, m0, m1 with one idle cycle between each.
- m1 drops `cyc` mid-transfer: `s_cyc_o` low same cycle, `gnt_o=00` next cycle, later slave ack ignored, pending m0 granted afterwards.
- Reset asserted while `GNT0` waiting: next cycle all outputs 0, `gnt_o=00`; after release a m1 request is granted normally.
- With `USER_WB_ARB_TIMEOUT_EN`, `TIMEOUT=8`, slave never acks: `m0_ack_o=1`, `m0_dat_o=0xDEADBEEF`, `err_o` pulse on 8th granted cycle; slave ack on exactly that cycle → normal data, `err_o=0`.
- Without the macro, same stimulus: grant held for 1000 cycles, `err_o` stays 0, no master ack.
